// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, constants and config check for the debounce filter.
package debounce_pkg;
    typedef enum logic {IDLE, QUAL} dbnc_state_t;
    localparam int GLITCH_W = 8;
    function automatic bit dbnc_cnt_ok(input longint unsigned stable, input int unsigned width);
        return stable >= 1 && stable < (64'd1 << width);
    endfunction
endpackage

// File: rtl/dbnc_counter.sv
// dbnc_counter: qualification counter with sync clear, increment and terminal flag.
module dbnc_counter #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STABLE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
    // Compare one bit wider so cnt+1 cannot alias through wrap.
    assign term = (CNT_W+1)'(cnt) + (CNT_W+1)'(1) == (CNT_W+1)'(STABLE_CYC);
endmodule

// File: rtl/debounce.sv
// debounce: debounce filter with rise/fall pulses for a synchronized input.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 1000,
    parameter int unsigned CNT_W      = 16,
    parameter logic        RST_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_sig,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);
    if (!dbnc_cnt_ok(STABLE_CYC, CNT_W)) begin : g_bad_cfg
        $error("debounce: STABLE_CYC must be in 1 .. 2**CNT_W-1");
    end
    dbnc_state_t state;
    logic diff, term, done;
    assign diff = in_sig != level;
    // Counter is zero in IDLE, so term there means STABLE_CYC == 1.
    assign done = diff && term;
    dbnc_counter #(.CNT_W(CNT_W), .STABLE_CYC(STABLE_CYC)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!diff || term),
        .inc  (diff && !term),
        .term (term)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= RST_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= (diff && !term) ? QUAL : IDLE;
            busy  <= diff && !term;
            rise  <= done && !level;
            fall  <= done && level;
            if (done) level <= !level;
        end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_cnt <= '0;
        else if (state == QUAL && !diff && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: randomized and directed checks of debounce against a sample-history model.
module tb_debounce;
    logic clk = 1'b0, rst_n = 1'b0, in4 = 1'b0, in1 = 1'b0;
    logic lvl4, rise4, fall4, busy4, lvl1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gc4, gc1;
`endif
    int errors = 0, checks = 0;
    bit h[2][0:3];
    int hn[2];
    bit m_lvl[2], m_rise[2], m_fall[2], m_busy[2];
    int m_glitch[2];

    always #5 clk = ~clk;

    debounce #(.STABLE_CYC(4), .CNT_W(16), .RST_LEVEL(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_sig(in4), .level(lvl4), .rise(rise4), .fall(fall4), .busy(busy4)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(gc4)
`endif
    );
    debounce #(.STABLE_CYC(1), .CNT_W(4), .RST_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_sig(in1), .level(lvl1), .rise(rise1), .fall(fall1), .busy(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(gc1)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            hn[m] = 0; m_lvl[m] = 0; m_rise[m] = 0; m_fall[m] = 0; m_busy[m] = 0; m_glitch[m] = 0;
        end
    endtask

    // A new level is accepted once the last N samples since reset all differ from it.
    task automatic model_step(input int m, input bit s);
        int n;
        bit all_diff;
        n = (m == 0) ? 4 : 1;
        for (int j = 3; j > 0; j--) h[m][j] = h[m][j-1];
        h[m][0] = s;
        if (hn[m] < 4) hn[m]++;
        all_diff = hn[m] >= n;
        for (int j = 0; j < n; j++) if (h[m][j] == m_lvl[m]) all_diff = 0;
        m_rise[m] = 0;
        m_fall[m] = 0;
        if (s == m_lvl[m] && m_busy[m] && m_glitch[m] < 255) m_glitch[m]++;
        if (all_diff) begin
            m_rise[m] = !m_lvl[m];
            m_fall[m] = m_lvl[m];
            m_lvl[m] = !m_lvl[m];
        end
        m_busy[m] = s != m_lvl[m];
    endtask

    task automatic compare_all();
        check("level4", lvl4, m_lvl[0]);
        check("rise4", rise4, m_rise[0]);
        check("fall4", fall4, m_fall[0]);
        check("busy4", busy4, m_busy[0]);
        check("level1", lvl1, m_lvl[1]);
        check("rise1", rise1, m_rise[1]);
        check("fall1", fall1, m_fall[1]);
        check("busy1", busy1, m_busy[1]);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch4", gc4, m_glitch[0]);
        check("glitch1", gc1, m_glitch[1]);
`endif
    endtask

    task automatic tick();
        bit s0, s1;
        s0 = in4;
        s1 = in1;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model_step(0, s0);
            model_step(1, s1);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int busy_n, rise_n, fall_n, rise_at;
        model_reset();
        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            in4 = ~in4;
            in1 = 1'($urandom);
            tick();
        end
        in4 = 0;
        rst_n = 1;
        tick();
        // Clean rise
        in4 = 1;
        busy_n = 0; rise_n = 0; fall_n = 0; rise_at = -1;
        for (int i = 0; i < 10; i++) begin
            in1 = 1'($urandom);
            tick();
            busy_n += int'(busy4);
            fall_n += int'(fall4);
            if (rise4) begin rise_n++; rise_at = i; end
        end
        check("rise_busy_cycles", busy_n, 3);
        check("rise_pulses", rise_n, 1);
        check("rise_edge", rise_at, 3);
        check("rise_no_fall", fall_n, 0);
        check("rise_level", lvl4, 1);
        // Glitch against level 1: three low samples then back high
        in4 = 0;
        for (int i = 0; i < 3; i++) tick();
        in4 = 1;
        tick();
        check("glitch_level", lvl4, 1);
        check("glitch_busy", busy4, 0);
        // Clean fall
        in4 = 0;
        fall_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fall4) fall_n++;
        end
        check("fall_pulses", fall_n, 1);
        check("fall_level", lvl4, 0);
        // Reset mid-qualification
        in4 = 1;
        tick();
        tick();
        rst_n = 0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1;
        rise_at = -1;
        for (int i = 1; i <= 20 && rise_at < 0; i++) begin
            tick();
            if (rise4) rise_at = i;
        end
        check("post_reset_rise_edge", rise_at, 4);
        // Random bouncing inputs
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(2) == 0) in4 = ~in4;
            in1 = 1'($urandom);
            tick();
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        // Saturation: 300 one-sample glitches
        in4 = lvl4;
        tick();
        for (int i = 0; i < 300; i++) begin
            in4 = ~lvl4;
            tick();
            in4 = lvl4;
            tick();
        end
        check("glitch_saturate", gc4, 255);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
